// File: rtl/cineraria_core_nios2_mulx_seq_if.sv
// Operand/result handshake bundle for the sequential Nios II multiply unit.
// The requester (pipeline) is the master; the multiply unit is the slave.
interface cineraria_core_nios2_mulx_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        abort;
    logic        ready;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output op,
        output src1,
        output src2,
        output abort,
        input  ready,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  src1,
        input  src2,
        input  abort,
        output ready,
        output done,
        output result
    );
endinterface

// File: rtl/cineraria_core_nios2_mulx_seq.sv
// Sequential 32x32 multiply (MUL / MULXUU / MULXSU / MULXSS) built from one registered
// 16x16 unsigned multiplier; operands are sign-stripped up front and the sign restored at the end.
module cineraria_core_nios2_mulx_seq #(
    parameter bit EARLY_MUL = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    cineraria_core_nios2_mulx_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX
    } state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] mult_q, mult_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        accept;
    logic        src1_signed;
    logic        src2_signed;
    logic        neg_in;
    logic [1:0]  last_idx;
    logic [1:0]  acc_idx;
    logic [5:0]  shamt;
    logic [15:0] a_half;
    logic [15:0] b_half;
    logic [31:0] prod;
    logic [63:0] addend;
    logic [63:0] acc_neg;

    assign accept      = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign src1_signed = (bus.op == OP_MULXSU) || (bus.op == OP_MULXSS);
    assign src2_signed = (bus.op == OP_MULXSS);

    always_comb begin
        unique case (bus.op)
            OP_MULXSS: neg_in = bus.src1[31] ^ bus.src2[31];
            OP_MULXSU: neg_in = bus.src1[31];
            default:   neg_in = 1'b0;
        endcase
    end

    // MUL only needs the low word, and a_h*b_h only touches bits 63:32.
    assign last_idx = (EARLY_MUL && (op_q == OP_MUL)) ? 2'd2 : 2'd3;

    // Partial product issue order: a_l*b_l, a_h*b_l, a_l*b_h, a_h*b_h.
    always_comb begin
        unique case (cnt_q)
            2'd0: begin a_half = a_q[15:0];  b_half = b_q[15:0];  end
            2'd1: begin a_half = a_q[31:16]; b_half = b_q[15:0];  end
            2'd2: begin a_half = a_q[15:0];  b_half = b_q[31:16]; end
            default: begin a_half = a_q[31:16]; b_half = b_q[31:16]; end
        endcase
    end

    assign prod = {16'b0, a_half} * {16'b0, b_half};

    // mult_q always holds the product issued one cycle earlier.
    assign acc_idx = (state_q == S_DRAIN) ? last_idx : (cnt_q - 2'd1);

    always_comb begin
        unique case (acc_idx)
            2'd0:    shamt = 6'd0;
            2'd3:    shamt = 6'd32;
            default: shamt = 6'd16;
        endcase
    end

    assign addend  = {32'b0, mult_q} << shamt;
    assign acc_neg = ~acc_q + 64'd1;

    // NOTE: every *_d gets a default first so no path through the block leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (state_q == S_ISSUE) begin
            mult_d = prod;
        end

        if (((state_q == S_ISSUE) && (cnt_q != 2'd0)) || (state_q == S_DRAIN)) begin
            acc_d = acc_q + addend;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = bus.op;
                    neg_d   = neg_in;
                    a_d     = src1_signed ? magnitude(bus.src1) : bus.src1;
                    b_d     = src2_signed ? magnitude(bus.src2) : bus.src2;
                    acc_d   = 64'd0;
                    cnt_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == last_idx) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q == OP_MUL) begin
                    result_d = acc_q[31:0];
                end else begin
                    result_d = neg_q ? acc_neg[63:32] : acc_q[63:32];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including the completing FIX cycle.
        if (bus.abort) begin
            state_d  = S_IDLE;
            cnt_d    = 2'd0;
            acc_d    = 64'd0;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            op_q     <= 2'd0;
            neg_q    <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mult_q   <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
